// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO between the fetcher and the decoder/issue
// stage. Each entry carries {instruction, PC, predicted-taken bit}. The oldest
// entry is presented combinationally on head_*, and a redirect flushes the
// whole queue in a single cycle.
//
// Handshake: a push is accepted on a rising edge with rdy_in=1 when
// push_valid=1 and full=0 (full is taken from the current count, so a
// simultaneous pop does not make room). A pop is accepted on a rising edge
// with rdy_in=1 when pop_ready=1 and head_valid=1. flush_in overrides both.
// With rdy_in=0, nothing changes.
module inst_queue #(
    parameter int DEPTH_LOG = 4,
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 push_valid,
    input  logic [INST_W-1:0]    push_inst,
    input  logic [ADDR_W-1:0]    push_pc,
    input  logic                 push_pred,
    output logic                 full,
    output logic                 almost_full,
    input  logic                 pop_ready,
    output logic                 head_valid,
    output logic [INST_W-1:0]    head_inst,
    output logic [ADDR_W-1:0]    head_pc,
    output logic                 head_pred,
    output logic [DEPTH_LOG:0]   count
);

    localparam int DEPTH      = 1 << DEPTH_LOG;
    localparam int AFULL_LVL  = DEPTH - 2;

    localparam logic [DEPTH_LOG:0]   CNT_FULL  = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   CNT_AFULL = (DEPTH_LOG+1)'(AFULL_LVL);
    localparam logic [DEPTH_LOG:0]   CNT_ONE   = (DEPTH_LOG+1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE   = DEPTH_LOG'(1);

    // Entry storage; contents are meaningful only between head and tail, so
    // it is never reset.
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic              pred_mem_q [DEPTH];

    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;

    logic push_acc;
    logic pop_acc;
    logic wr_en;

    // Status flags derive purely from the registered count.
    always_comb begin
        full        = (count_q == CNT_FULL);
        almost_full = (count_q >= CNT_AFULL);
        head_valid  = (count_q != '0);
        count       = count_q;
        push_acc    = push_valid && !full;
        pop_acc     = pop_ready && head_valid;
    end

    // Head read path: oldest entry, forced to zero when empty so the decoder
    // sees a harmless op-0 instruction.
    always_comb begin
        head_inst = '0;
        head_pc   = '0;
        head_pred = 1'b0;
        if (head_valid) begin
            head_inst = inst_mem_q[head_q];
            head_pc   = pc_mem_q[head_q];
            head_pred = pred_mem_q[head_q];
        end
    end

    // Next-state for pointers and count: rdy_in gates everything, flush wins
    // over push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (rdy_in) begin
            if (flush_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push_acc) begin
                    tail_d = tail_q + PTR_ONE;
                    wr_en  = 1'b1;
                end
                if (pop_acc) begin
                    head_d = head_q + PTR_ONE;
                end
                case ({push_acc, pop_acc})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Pointer/count registers; reset empties the queue immediately.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at the tail when a push is accepted.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            inst_mem_q[tail_q] <= push_inst;
            pc_mem_q[tail_q]   <= push_pc;
            pred_mem_q[tail_q] <= push_pred;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: fill/drain ordering, full/almost_full
// thresholds, concurrent push+pop with pointer wrap, flush priority, rdy_in
// gating and asynchronous reset.
module tb_inst_queue;

    localparam int DEPTH_LOG = 4;
    localparam int INST_W    = 32;
    localparam int ADDR_W    = 32;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                rdy_in;
    logic                flush_in;
    logic                push_valid;
    logic [INST_W-1:0]   push_inst;
    logic [ADDR_W-1:0]   push_pc;
    logic                push_pred;
    logic                full;
    logic                almost_full;
    logic                pop_ready;
    logic                head_valid;
    logic [INST_W-1:0]   head_inst;
    logic [ADDR_W-1:0]   head_pc;
    logic                head_pred;
    logic [DEPTH_LOG:0]  count;

    inst_queue #(
        .DEPTH_LOG(DEPTH_LOG),
        .INST_W   (INST_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .push_valid (push_valid),
        .push_inst  (push_inst),
        .push_pc    (push_pc),
        .push_pred  (push_pred),
        .full       (full),
        .almost_full(almost_full),
        .pop_ready  (pop_ready),
        .head_valid (head_valid),
        .head_inst  (head_inst),
        .head_pc    (head_pc),
        .head_pred  (head_pred),
        .count      (count)
    );

    // ---------------- scoreboard ----------------
    // Expected PCs in FIFO order; instructions in the bulk tests are derived
    // from the PC as 0xA000_0000 | pc.
    logic [ADDR_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // ---------------- driver tasks ----------------
    // Apply one cycle of inputs, advance past the rising edge, then idle.
    task automatic drive(input logic pv, input logic [INST_W-1:0] inst,
                         input logic [ADDR_W-1:0] pc, input logic pred,
                         input logic pr, input logic fl);
        push_valid = pv;
        push_inst  = inst;
        push_pc    = pc;
        push_pred  = pred;
        pop_ready  = pr;
        flush_in   = fl;
        @(posedge clk_in);
        #1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush_in   = 1'b0;
    endtask

    task automatic push_bulk(input int n, input logic [ADDR_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] pc;
            pc = base + ADDR_W'(4 * i);
            drive(1'b1, 32'hA000_0000 | pc, pc, pc[2], 1'b0, 1'b0);
            exp_q.push_back(pc);
        end
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        #12;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n_in   = 1'b0;
        rdy_in     = 1'b1;
        flush_in   = 1'b0;
        push_valid = 1'b0;
        push_inst  = '0;
        push_pc    = '0;
        push_pred  = 1'b0;
        pop_ready  = 1'b0;
        #12;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", almost_full); end
        n_cmp++; if (head_valid !== 1'b0) begin n_err++; $display("FAIL reset_head_valid: got %b want 0", head_valid); end
        n_cmp++; if (head_inst !== 32'h0) begin n_err++; $display("FAIL reset_head_inst: got %h want 0", head_inst); end
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_basic();
        logic [INST_W-1:0] insts [3];
        logic [ADDR_W-1:0] pcs [3];
        logic              preds [3];
        insts = '{32'h00500093, 32'h00100113, 32'hfe209ee3};
        pcs   = '{32'h0, 32'h4, 32'h8};
        preds = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) drive(1'b1, insts[i], pcs[i], preds[i], 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (head_inst !== insts[i]) begin n_err++; $display("FAIL basic_head_inst[%0d]: got %h want %h", i, head_inst, insts[i]); end
            n_cmp++; if (head_pc !== pcs[i]) begin n_err++; $display("FAIL basic_head_pc[%0d]: got %h want %h", i, head_pc, pcs[i]); end
            n_cmp++; if (head_pred !== preds[i]) begin n_err++; $display("FAIL basic_head_pred[%0d]: got %b want %b", i, head_pred, preds[i]); end
            drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        end
        n_cmp++; if (head_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty_valid: got %b want 0", head_valid); end
        n_cmp++; if (head_inst !== 32'h0) begin n_err++; $display("FAIL basic_empty_inst: got %h want 0", head_inst); end
        // pop on an empty queue must not underflow
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL basic_pop_empty: got %0d want 0", count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            logic [ADDR_W-1:0] pc;
            pc = ADDR_W'(4 * i);
            drive(1'b1, 32'hA000_0000 | pc, pc, pc[2], 1'b0, 1'b0);
            exp_q.push_back(pc);
            n_cmp++; if (almost_full !== (i + 1 >= 14)) begin n_err++; $display("FAIL full_afull@%0d: got %b want %b", i + 1, almost_full, (i + 1 >= 14)); end
            n_cmp++; if (full !== (i + 1 == 16)) begin n_err++; $display("FAIL full_flag@%0d: got %b want %b", i + 1, full, (i + 1 == 16)); end
        end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d want 16", count); end
        // 17th push with concurrent pop: pop happens, push is rejected
        drive(1'b1, 32'hA000_0040, 32'h40, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL full_reject_count: got %0d want 15", count); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL full_reject_full: got %b want 0", full); end
        while (exp_q.size() > 0) begin
            logic [ADDR_W-1:0] pc;
            pc = exp_q.pop_front();
            n_cmp++; if (head_pc !== pc || head_inst !== (32'hA000_0000 | pc)) begin n_err++; $display("FAIL full_drain: got pc %h inst %h want pc %h", head_pc, head_inst, pc); end
            drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        end
        n_cmp++; if (head_valid !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL full_drained: got valid %b count %0d want 0/0", head_valid, count); end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] next_pc;
        push_bulk(5, 32'h1000);
        next_pc = 32'h1014;
        for (int i = 0; i < 40; i++) begin
            logic [ADDR_W-1:0] pc;
            pc = exp_q.pop_front();
            n_cmp++; if (head_pc !== pc) begin n_err++; $display("FAIL b2b_head_pc[%0d]: got %h want %h", i, head_pc, pc); end
            drive(1'b1, 32'hA000_0000 | next_pc, next_pc, next_pc[2], 1'b1, 1'b0);
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'h4;
            n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 5", i, count); end
        end
        while (exp_q.size() > 0) begin
            logic [ADDR_W-1:0] pc;
            pc = exp_q.pop_front();
            n_cmp++; if (head_pc !== pc || head_pred !== pc[2]) begin n_err++; $display("FAIL b2b_drain: got pc %h pred %b want pc %h", head_pc, head_pred, pc); end
            drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        push_bulk(7, 32'h2000);
        n_cmp++; if (count !== 5'd7) begin n_err++; $display("FAIL flush_pre_count: got %0d want 7", count); end
        drive(1'b1, 32'hDEAD_BEEF, 32'h2100, 1'b1, 1'b1, 1'b1);
        exp_q.delete();
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (head_valid !== 1'b0) begin n_err++; $display("FAIL flush_head_valid: got %b want 0", head_valid); end
        drive(1'b1, 32'h00000013, 32'h3000, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (head_valid !== 1'b1 || head_pc !== 32'h3000 || head_inst !== 32'h00000013) begin n_err++; $display("FAIL flush_next_push: got valid %b pc %h inst %h want 1/3000/00000013", head_valid, head_pc, head_inst); end
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL flush_next_count: got %0d want 1", count); end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_rdy_gate();
        push_bulk(2, 32'h4000);
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1111_1111, 32'h5000, 1'b0, 1'b1, (i >= 2));
            n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL rdy_count[%0d]: got %0d want 2", i, count); end
            n_cmp++; if (head_pc !== 32'h4000) begin n_err++; $display("FAIL rdy_head_pc[%0d]: got %h want 4000", i, head_pc); end
        end
        rdy_in = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        n_cmp++; if (count !== 5'd1 || head_pc !== 32'h4004) begin n_err++; $display("FAIL rdy_resume: got count %0d pc %h want 1/4004", count, head_pc); end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        push_bulk(9, 32'h6000);
        n_cmp++; if (count !== 5'd9) begin n_err++; $display("FAIL arst_pre_count: got %0d want 9", count); end
        #2;
        rst_n_in = 1'b0;
        #1;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", count); end
        n_cmp++; if (head_valid !== 1'b0 || head_inst !== 32'h0 || head_pc !== 32'h0 || head_pred !== 1'b0) begin n_err++; $display("FAIL arst_head: got valid %b inst %h pc %h pred %b want all 0", head_valid, head_inst, head_pc, head_pred); end
        n_cmp++; if (almost_full !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL arst_flags: got afull %b full %b want 0/0", almost_full, full); end
        exp_q.delete();
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        drive(1'b1, 32'h00A00513, 32'h7000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (count !== 5'd1 || head_valid !== 1'b1 || head_pc !== 32'h7000 || head_inst !== 32'h00A00513) begin n_err++; $display("FAIL arst_first_push: got count %0d valid %b pc %h inst %h want 1/1/7000/00a00513", count, head_valid, head_pc, head_inst); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_flush();
        test_rdy_gate();
        test_async_reset();
        do_reset();
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL final_reset_count: got %0d want 0", count); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO between the instruction fetcher and the decoder/issue stage.
- Buffers fetched 32-bit instructions together with their PC and the fetcher's branch-prediction bit.
- Presents the oldest entry combinationally to the decoder, and pops it when issue accepts it.
- Flushed wholesale on a branch misprediction or other redirect.

Parameters:
- DEPTH_LOG, 4, log2 of entry count (DEPTH = 16).
- INST_W, 32, instruction width.
- ADDR_W, 32, PC width.

Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; when low, no state changes.
- flush_in  input  1  discard all entries.
- push_valid  input  1  fetcher offers an entry.
- push_inst  input  INST_W  fetched instruction.
- push_pc  input  ADDR_W  PC of push_inst.
- push_pred  input  1  predicted-taken bit.
- full  output  1  count == DEPTH; the fetcher must not rely on a push being accepted.
- almost_full  output  1  count >= DEPTH-2, registered-pipeline backoff for the fetcher.
- pop_ready  input  1  issue stage consumes the head this cycle.
- head_valid  output  1  queue non-empty.
- head_inst  output  INST_W  oldest instruction, feeds the decoder.
- head_pc  output  ADDR_W  PC of head.
- head_pred  output  1  prediction bit of head.
- count  output  DEPTH_LOG+1  number of valid entries.

Behaviour:
- Reset: rst_n_in low asynchronously clears head pointer, tail pointer and count to 0.
  - Consequently full=0, almost_full=0, head_valid=0, head_inst/head_pc/head_pred=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- State: head ptr, tail ptr (DEPTH_LOG bits each, wrap modulo DEPTH) and count register. full, almost_full and head_valid derive from count.
- Update gating: all updates happen on the rising edge and only when rdy_in=1. With rdy_in=0, the queue holds and pushes/pops are ignored.
- Priority at an edge with rdy_in=1: flush > push/pop.
- flush_in=1:
  - head=tail=count=0 at the edge.
  - A push or pop in the same cycle is dropped and has no effect.
  - head_valid is 0 in the next cycle.
- Push acceptance: push_valid && !full.
  - Writes {inst, pc, pred} at tail; tail <= tail+1.
- Pop acceptance: pop_ready && head_valid.
  - head <= head+1.
  - pop_ready while empty is ignored.
- Full queue: full is evaluated on the current count, so a push with full=1 is rejected even if a pop happens in the same cycle. The fetcher must hold or refetch.
- Count update:
  - Push and pop together: count unchanged.
  - Push only: count+1.
  - Pop only: count-1.
  - count never exceeds DEPTH and never underflows.
- Head read path: combinational mux of storage[head] when count != 0; all-zero when empty.
  - An all-zero head_inst decodes to op 0 downstream, so the decoder sees a harmless no-op.
- Latency: an entry pushed at edge N is visible on head_* after edge N (one cycle); no same-cycle bypass from push to head.
- Ordering: strict FIFO. Pointer wrap from DEPTH-1 to 0 is transparent.
- Width rule: count is DEPTH_LOG+1 bits so that DEPTH is representable; pointers are DEPTH_LOG bits with natural overflow.

Test Plan:
- Reset, then push 3 entries (inst 0x00500093 pc 0x0, 0x00100113 pc 0x4, 0xfe209ee3 pc 0x8 pred 1) with pop_ready=0.
  - count=3, head_inst=0x00500093, head_pc=0x0.
  - Pop 3 times: heads appear in order; then head_valid=0 and head_inst=0.
- Push 16 entries (pc 0x0..0x3c).
  - full=1, almost_full=1 from count 14.
  - A 17th push with pc 0x40 while pop_ready=1: pop occurs, push rejected, count=15; 0x40 never appears.
- At count=5, push and pop in the same cycle for 40 cycles.
  - count stays 5; pointers wrap past 15; head PCs increase monotonically by 4.
- At count=7, assert flush_in together with push_valid and pop_ready.
  - Next cycle count=0, head_valid=0; the next push appears at head one cycle later.
- rdy_in=0 for 4 cycles with push_valid=1 and pop_ready=1 at count=2.
  - count stays 2 and head is unchanged; flush_in during rdy_in=0 is ignored.
- At count=9, drop rst_n_in between edges.
  - Outputs go to 0 immediately, asynchronously; after release, the first push is accepted normally.
